// File: rtl/plic_pkg.sv
// ---------------------------------------------------------------------------
// plic_pkg
// Shared definitions for the PLIC interrupt path: gateway FSM state encoding,
// trigger-mode encodings of the core TM register bit and the source count.
// ---------------------------------------------------------------------------
package plic_pkg;

  // Gateway request state: waiting for activity, requesting, or blocked
  // until the core signals completion.
  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_REQ  = 2'd1,
    GW_BUSY = 2'd2
  } plic_gw_state_e;

  localparam logic PLIC_TM_LEVEL = 1'b0;
  localparam logic PLIC_TM_EDGE  = 1'b1;

  // External sources 1..31 (ID 0 is reserved for "no interrupt").
  localparam int PLIC_IRQ_NUM = 31;

endpackage

// File: rtl/plic_sync.sv
// ---------------------------------------------------------------------------
// plic_sync
// Generic flop-chain synchroniser for an input asynchronous to i_clk.
// All stages clear on reset.
//
// Ports:
//   i_clk   in  1  destination clock
//   i_rst_n in  1  asynchronous active-low reset
//   i_d     in  1  asynchronous input
//   o_q     out 1  synchronised output (last stage)
// ---------------------------------------------------------------------------
module plic_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/plic_irq_gateway.sv
// ---------------------------------------------------------------------------
// plic_irq_gateway
// Per-source interrupt gateway in front of the PLIC core. Synchronises the
// raw device line, turns level or rising-edge activity into one outstanding
// request, holds it until the core accepts it, then blocks the source until
// completion. In edge mode extra edges are queued in a saturating counter.
//
// Ports:
//   pclk        in  1          block clock (core/APB clock)
//   presetn     in  1          asynchronous active-low reset
//   irq_i       in  1          raw device interrupt (asynchronous)
//   tm_i        in  1          trigger mode: 0 = level, 1 = rising edge
//   ready_i     in  1          core can accept a request
//   comp_i      in  1          one-cycle completion pulse for this source
//   valid_o     out 1          request to the core
//   pend_cnt_o  out CNT_WIDTH  queued edges not yet forwarded
//   ovf_o       out 1          sticky: edge arrived while counter saturated
// ---------------------------------------------------------------------------
module plic_irq_gateway
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 irq_i,
  input  logic                 tm_i,
  input  logic                 ready_i,
  input  logic                 comp_i,
  output logic                 valid_o,
  output logic [CNT_WIDTH-1:0] pend_cnt_o,
  output logic                 ovf_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  plic_gw_state_e       r_state;
  plic_gw_state_e       w_state_nxt;
  logic                 r_irq_s_d;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_ovf;
  logic                 w_ovf_nxt;
  logic                 r_valid;

  logic w_irq_s;
  logic w_rise;
  logic w_edge_mode;
  logic w_accept;
  logic w_dec;
  logic w_req_cond;

  plic_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (pclk),
    .i_rst_n (presetn),
    .i_d     (irq_i),
    .o_q     (w_irq_s)
  );

  assign w_rise      = w_irq_s & ~r_irq_s_d;
  assign w_edge_mode = (tm_i == PLIC_TM_EDGE);
  assign w_accept    = (r_state == GW_REQ) & ready_i;
  // A request raised in level mode may be accepted after a switch to edge
  // mode with nothing queued; the guard keeps the counter from wrapping.
  assign w_dec       = w_accept & (r_cnt != CNT_ZERO);
  assign w_req_cond  = w_edge_mode ? ((r_cnt != CNT_ZERO) | w_rise) : w_irq_s;

  // Next-state logic of the request FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      GW_IDLE: begin
        if (w_req_cond) begin
          w_state_nxt = GW_REQ;
        end else begin
          w_state_nxt = GW_IDLE;
        end
      end
      GW_REQ: begin
        if (ready_i) begin
          w_state_nxt = GW_BUSY;
        end else begin
          w_state_nxt = GW_REQ;
        end
      end
      GW_BUSY: begin
        if (comp_i) begin
          w_state_nxt = GW_IDLE;
        end else begin
          w_state_nxt = GW_BUSY;
        end
      end
      default: begin
        w_state_nxt = GW_IDLE;
      end
    endcase
  end

  // Edge counter and overflow flag. A rise and an acceptance in the same
  // cycle cancel, so no decrement is lost even when saturated.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (!w_edge_mode) begin
      w_cnt_nxt = CNT_ZERO;
    end else if (w_rise && w_dec) begin
      w_cnt_nxt = r_cnt;
    end else if (w_rise) begin
      if (r_cnt == CNT_MAX) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end else if (w_dec) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // State, edge-detect delay, counter and registered request output.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= GW_IDLE;
      r_irq_s_d <= 1'b0;
      r_cnt     <= CNT_ZERO;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq_s_d <= w_irq_s;
      r_cnt     <= w_cnt_nxt;
      r_ovf     <= w_ovf_nxt;
      r_valid   <= (w_state_nxt == GW_REQ);
    end
  end

  assign valid_o    = r_valid;
  assign pend_cnt_o = r_cnt;
  assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_plic_irq_gateway.sv
// ---------------------------------------------------------------------------
// tb_plic_irq_gateway
// Self-checking bench for plic_irq_gateway. Two instances share stimulus:
// dut (defaults) and dut2 (CNT_WIDTH=2) for the saturation scenario.
// Expected values are pushed to exp_q when stimulus is driven and popped
// when the corresponding DUT output is sampled (#1 after the clock edge).
// ---------------------------------------------------------------------------
module tb_plic_irq_gateway;
  import plic_pkg::*;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       irq_i;
  logic       tm_i;
  logic       ready_i;
  logic       comp_i;
  logic       valid_o;
  logic [3:0] pend_cnt_o;
  logic       ovf_o;
  logic       valid2;
  logic [1:0] cnt2;
  logic       ovf2;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          acc_base;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  plic_irq_gateway #(.SYNC_STAGES(2), .CNT_WIDTH(4)) dut (
    .pclk(pclk), .presetn(presetn), .irq_i(irq_i), .tm_i(tm_i),
    .ready_i(ready_i), .comp_i(comp_i), .valid_o(valid_o),
    .pend_cnt_o(pend_cnt_o), .ovf_o(ovf_o)
  );

  plic_irq_gateway #(.SYNC_STAGES(2), .CNT_WIDTH(2)) dut2 (
    .pclk(pclk), .presetn(presetn), .irq_i(irq_i), .tm_i(tm_i),
    .ready_i(ready_i), .comp_i(comp_i), .valid_o(valid2),
    .pend_cnt_o(cnt2), .ovf_o(ovf2)
  );

  always #5 pclk = ~pclk;

  // Count accepted requests (valid & ready seen at a clock edge).
  always @(posedge pclk) begin
    if (presetn && valid_o && ready_i) n_acc <= n_acc + 1;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic apply_reset();
    presetn = 1'b0; irq_i = 1'b0; tm_i = 1'b0; ready_i = 1'b0; comp_i = 1'b0;
    step(2);
    presetn = 1'b1;
  endtask

  task automatic pulse(input int hi, input int lo);
    irq_i = 1'b1; step(hi);
    irq_i = 1'b0; step(lo);
  endtask

  task automatic test_reset();
    presetn = 1'b0; irq_i = 1'b1; tm_i = 1'b1; ready_i = 1'b1; comp_i = 1'b0;
    exp_q.push_back(32'd0);
    step(3);
    n_checks++; e = exp_q.pop_front();
    if ({valid_o, pend_cnt_o, ovf_o} !== e[5:0]) begin
      n_fail++; $display("FAIL reset_outputs got %b exp %b", {valid_o, pend_cnt_o, ovf_o}, e[5:0]);
    end
    n_checks++;
    if (dut.r_state !== GW_IDLE) begin
      n_fail++; $display("FAIL reset_state got %0d exp %0d", dut.r_state, GW_IDLE);
    end
  endtask

  task automatic test_level_basic();
    apply_reset();
    tm_i = PLIC_TM_LEVEL; ready_i = 1'b1; irq_i = 1'b1;
    exp_q.push_back(32'd0);
    step(2);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== e[0]) begin
      n_fail++; $display("FAIL lvl_early valid_o got %0b exp %0b", valid_o, e[0]);
    end
    exp_q.push_back(32'd1);
    step(1);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== e[0]) begin
      n_fail++; $display("FAIL lvl_latency valid_o got %0b exp %0b", valid_o, e[0]);
    end
    exp_q.push_back(GW_BUSY);
    step(1);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== 1'b0 || dut.r_state !== plic_gw_state_e'(e[1:0])) begin
      n_fail++; $display("FAIL lvl_accept valid_o=%0b state got %0d exp %0d", valid_o, dut.r_state, e[1:0]);
    end
    step(6);
    comp_i = 1'b1;
    exp_q.push_back(GW_IDLE);
    step(1);
    comp_i = 1'b0;
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== 1'b0 || dut.r_state !== plic_gw_state_e'(e[1:0])) begin
      n_fail++; $display("FAIL lvl_comp_idle valid_o=%0b state got %0d exp %0d", valid_o, dut.r_state, e[1:0]);
    end
    exp_q.push_back(32'd1);
    step(1);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== e[0]) begin
      n_fail++; $display("FAIL lvl_rereq valid_o got %0b exp %0b", valid_o, e[0]);
    end
    irq_i = 1'b0;
    step(1);
    comp_i = 1'b1; step(1); comp_i = 1'b0;
    exp_q.push_back(32'd0);
    step(3);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== e[0] || dut.r_state !== GW_IDLE) begin
      n_fail++; $display("FAIL lvl_quiet valid_o got %0b exp %0b state %0d", valid_o, e[0], dut.r_state);
    end
  endtask

  task automatic test_level_hold();
    apply_reset();
    tm_i = PLIC_TM_LEVEL; ready_i = 1'b0; irq_i = 1'b1;
    step(3);
    irq_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'd1);
      step(1);
      n_checks++; e = exp_q.pop_front();
      if (valid_o !== e[0]) begin
        n_fail++; $display("FAIL lvl_hold[%0d] valid_o got %0b exp %0b", i, valid_o, e[0]);
      end
    end
    ready_i = 1'b1;
    exp_q.push_back(GW_BUSY);
    step(1);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== 1'b0 || dut.r_state !== plic_gw_state_e'(e[1:0])) begin
      n_fail++; $display("FAIL lvl_hold_accept valid_o=%0b state got %0d exp %0d", valid_o, dut.r_state, e[1:0]);
    end
    comp_i = 1'b1; step(1); comp_i = 1'b0;
    exp_q.push_back(32'd0);
    step(3);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== e[0]) begin
      n_fail++; $display("FAIL lvl_hold_release valid_o got %0b exp %0b", valid_o, e[0]);
    end
  endtask

  task automatic test_edge_burst();
    apply_reset();
    tm_i = PLIC_TM_EDGE; ready_i = 1'b1; irq_i = 1'b1;
    acc_base = n_acc;
    exp_q.push_back(32'd1);
    step(3);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== e[0]) begin
      n_fail++; $display("FAIL edge_latency valid_o got %0b exp %0b", valid_o, e[0]);
    end
    exp_q.push_back(32'd0);
    step(1);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== 1'b0 || pend_cnt_o !== e[3:0]) begin
      n_fail++; $display("FAIL edge_first_accept valid_o=%0b cnt got %0d exp %0d", valid_o, pend_cnt_o, e[3:0]);
    end
    irq_i = 1'b0; step(4);
    for (int i = 0; i < 3; i++) pulse(4, 4);
    exp_q.push_back(32'd3);
    n_checks++; e = exp_q.pop_front();
    if (pend_cnt_o !== e[3:0] || valid_o !== 1'b0 || ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL edge_burst_cnt got %0d exp %0d valid=%0b ovf=%0b", pend_cnt_o, e[3:0], valid_o, ovf_o);
    end
    for (int i = 0; i < 3; i++) begin
      comp_i = 1'b1; step(1); comp_i = 1'b0;
      exp_q.push_back(32'd1);
      step(1);
      n_checks++; e = exp_q.pop_front();
      if (valid_o !== e[0]) begin
        n_fail++; $display("FAIL edge_b2b_req[%0d] valid_o got %0b exp %0b", i, valid_o, e[0]);
      end
      exp_q.push_back(32'(2 - i));
      step(1);
      n_checks++; e = exp_q.pop_front();
      if (pend_cnt_o !== e[3:0]) begin
        n_fail++; $display("FAIL edge_drain[%0d] cnt got %0d exp %0d", i, pend_cnt_o, e[3:0]);
      end
    end
    comp_i = 1'b1; step(1); comp_i = 1'b0;
    exp_q.push_back(32'd4);
    step(4);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== 1'b0 || (n_acc - acc_base) !== int'(e)) begin
      n_fail++; $display("FAIL edge_no_extra valid_o=%0b accepts got %0d exp %0d", valid_o, n_acc - acc_base, e);
    end
  endtask

  task automatic test_edge_sat();
    apply_reset();
    tm_i = PLIC_TM_EDGE; ready_i = 1'b1;
    pulse(4, 4);
    for (int i = 0; i < 5; i++) pulse(4, 4);
    exp_q.push_back({27'd0, 1'b1, 2'd3, 1'b0, 1'b0});
    n_checks++; e = exp_q.pop_front();
    if ({ovf2, cnt2, valid2, ovf_o} !== e[4:0]) begin
      n_fail++; $display("FAIL sat_cnt2 {ovf,cnt,valid,ovf_w4} got %b exp %b", {ovf2, cnt2, valid2, ovf_o}, e[4:0]);
    end
    exp_q.push_back(32'd5);
    n_checks++; e = exp_q.pop_front();
    if (pend_cnt_o !== e[3:0]) begin
      n_fail++; $display("FAIL sat_cnt_w4 got %0d exp %0d", pend_cnt_o, e[3:0]);
    end
    for (int i = 0; i < 3; i++) begin
      comp_i = 1'b1; step(1); comp_i = 1'b0;
      exp_q.push_back({29'd0, 1'b1, 2'(2 - i)});
      step(2);
      n_checks++; e = exp_q.pop_front();
      if ({ovf2, cnt2} !== e[2:0]) begin
        n_fail++; $display("FAIL sat_drain[%0d] {ovf,cnt} got %b exp %b", i, {ovf2, cnt2}, e[2:0]);
      end
    end
    comp_i = 1'b1; step(1); comp_i = 1'b0;
    exp_q.push_back(32'd1);
    step(4);
    n_checks++; e = exp_q.pop_front();
    if (ovf2 !== e[0]) begin
      n_fail++; $display("FAIL sat_ovf_sticky got %0b exp %0b", ovf2, e[0]);
    end
  endtask

  task automatic test_simul();
    apply_reset();
    tm_i = PLIC_TM_EDGE; ready_i = 1'b1;
    pulse(4, 4);
    pulse(4, 4);
    pulse(4, 4);
    ready_i = 1'b0;
    comp_i = 1'b1; step(1); comp_i = 1'b0;
    exp_q.push_back(32'd1);
    step(1);
    n_checks++; e = exp_q.pop_front();
    if (valid_o !== e[0] || pend_cnt_o !== 4'd2) begin
      n_fail++; $display("FAIL simul_setup valid_o=%0b exp %0b cnt=%0d", valid_o, e[0], pend_cnt_o);
    end
    irq_i = 1'b1;
    step(2);
    ready_i = 1'b1;
    exp_q.push_back(32'd2);
    step(1);
    n_checks++; e = exp_q.pop_front();
    if (pend_cnt_o !== e[3:0] || cnt2 !== e[1:0] || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL simul_rise_accept cnt got %0d/%0d exp %0d valid=%0b", pend_cnt_o, cnt2, e[3:0], valid_o);
    end
    irq_i = 1'b0; step(4);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    exp_q.push_back(32'd0);
    n_checks++; e = exp_q.pop_front();
    if (ovf2 !== e[0]) begin
      n_fail++; $display("FAIL ovf_cleared_by_reset got %0b exp %0b", ovf2, e[0]);
    end
    tm_i = PLIC_TM_EDGE; ready_i = 1'b1;
    pulse(4, 4);
    pulse(4, 4);
    pulse(4, 4);
    exp_q.push_back({28'd0, 2'd2, GW_BUSY});
    n_checks++; e = exp_q.pop_front();
    if (pend_cnt_o !== e[5:2] || dut.r_state !== plic_gw_state_e'(e[1:0])) begin
      n_fail++; $display("FAIL mid_setup cnt got %0d exp %0d state %0d", pend_cnt_o, e[5:2], dut.r_state);
    end
    #3;
    presetn = 1'b0;
    exp_q.push_back(32'd0);
    #1;
    n_checks++; e = exp_q.pop_front();
    if ({valid_o, pend_cnt_o, ovf_o, cnt2} !== e[7:0] || dut.r_state !== GW_IDLE) begin
      n_fail++; $display("FAIL mid_reset got %b exp %b state %0d", {valid_o, pend_cnt_o, ovf_o, cnt2}, e[7:0], dut.r_state);
    end
    step(1);
    presetn = 1'b1;
    comp_i = 1'b1; step(1); comp_i = 1'b0;
    exp_q.push_back(32'd0);
    step(2);
    n_checks++; e = exp_q.pop_front();
    if ({valid_o, pend_cnt_o} !== e[4:0] || dut.r_state !== GW_IDLE) begin
      n_fail++; $display("FAIL comp_in_idle got %b exp %b state %0d", {valid_o, pend_cnt_o}, e[4:0], dut.r_state);
    end
  endtask

  initial begin
    test_reset();
    test_level_basic();
    test_level_hold();
    test_edge_burst();
    test_edge_sat();
    test_reset_mid();
    test_simul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
